// File: rtl/vector_data_memory_if.sv
// Request, store-data and load-data bundle for vector_data_memory.
// The master side issues vector requests; the slave side is the memory.
interface vector_data_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] req_stride;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              init_busy;

    modport master (
        output req_valid, req_we, req_base, req_stride, req_len, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_base, req_stride, req_len, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, done, init_busy
    );
endinterface

// File: rtl/vector_data_memory.sv
// Strided vector load/store memory with self-initialisation (mem[i] = i) after reset.
// Loads stream one element per cycle; stores advance only on accepted wdata beats.
module vector_data_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 4
) (
    input logic clk,
    input logic rst,
    vector_data_memory_if.slave io_bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, LOAD, STORE} state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_init_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_done;

    logic              w_req_ready;
    logic              w_wdata_ready;
    logic              w_init_busy;
    logic              w_accept;
    logic              w_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_init_busy   = 1'b0;
        w_accept      = 1'b0;
        w_last        = (r_remaining == LEN_W'(1));
        w_mem_we      = 1'b0;
        w_mem_addr    = r_addr;
        w_mem_wdata   = io_bus.wdata;
        case (r_state)
            INIT: begin
                w_init_busy = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_init_idx;
                w_mem_wdata = DATA_W'(r_init_idx);
                if (r_init_idx == ADDR_W'(DEPTH - 1)) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                w_req_ready = 1'b1;
                if (io_bus.req_valid) begin
                    w_accept = 1'b1;
                    if (io_bus.req_len != '0) begin
                        w_next_state = io_bus.req_we ? STORE : LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            STORE: begin
                w_wdata_ready = 1'b1;
                if (io_bus.wdata_valid) begin
                    w_mem_we = 1'b1;
                    if (w_last) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = INIT;
        endcase
    end

    // Storage has no reset: INIT rewrites every word after each reset anyway.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_idx    <= '0;
            r_addr        <= '0;
            r_stride      <= '0;
            r_remaining   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                INIT: begin
                    r_init_idx <= r_init_idx + ADDR_W'(1);
                end
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= io_bus.req_base;
                        r_stride    <= io_bus.req_stride;
                        r_remaining <= io_bus.req_len;
                        r_done      <= (io_bus.req_len == '0);
                    end
                end
                LOAD: begin
                    r_rdata       <= r_mem[r_addr];
                    r_rdata_valid <= 1'b1;
                    r_addr        <= r_addr + r_stride;
                    r_remaining   <= r_remaining - LEN_W'(1);
                    r_done        <= w_last;
                end
                STORE: begin
                    if (io_bus.wdata_valid) begin
                        r_addr      <= r_addr + r_stride;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_done      <= w_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.req_ready   = w_req_ready;
    assign io_bus.wdata_ready = w_wdata_ready;
    assign io_bus.init_busy   = w_init_busy;
    assign io_bus.rdata       = r_rdata;
    assign io_bus.rdata_valid = r_rdata_valid;
    assign io_bus.done        = r_done;
endmodule

// File: tb/tb_vector_data_memory.sv
// Scoreboard bench for vector_data_memory: tasks push expected load words,
// a negedge monitor pops and compares them whenever rdata_valid is high.
module tb_vector_data_memory;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t        expQ[$];
    exp_t        monExp;
    int          checks = 0;
    int          failures = 0;
    int          doneCount = 0;
    logic [31:0] model [32];
    logic [31:0] sd [4];

    vector_data_memory_if #(.DATA_W(32), .ADDR_W(5), .LEN_W(4)) bus ();

    vector_data_memory #(.DATA_W(32), .ADDR_W(5), .LEN_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every presented load word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) doneCount++;
            if (bus.rdata_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("rdata", bus.rdata, monExp.data);
                    checkOutput("done_with_last", {31'd0, bus.done}, {31'd0, monExp.last});
                end
            end
        end
    end

    task automatic resetModel();
        for (int i = 0; i < 32; i++) model[i] = i;
    endtask

    task automatic doReset();
        int n;
        rst = 1'b1;
        bus.req_valid   = 1'b0;
        bus.wdata_valid = 1'b0;
        #1;
        checkOutput("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);
        checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("rst_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        checkOutput("rst_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resetModel();
        n = 0;
        while (bus.init_busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("init_cycles", n, 32);
        checkOutput("ready_after_init", {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Presents a request and holds it until the handshake edge.
    task automatic applyStimulus(input logic we, input int base, input int stride, input int len);
        int n;
        bus.req_we     = we;
        bus.req_base   = 5'(base);
        bus.req_stride = 5'(stride);
        bus.req_len    = 4'(len);
        bus.req_valid  = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic doLoad(input int base, input int stride, input int len);
        int n;
        int dc;
        logic [31:0] lastVal;
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data  = model[(base + k * stride) % 32];
            e.last  = (k == len - 1);
            lastVal = e.data;
            expQ.push_back(e);
        end
        dc = doneCount;
        applyStimulus(1'b0, base, stride, len);
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("load_drain", expQ.size(), 32'd0);
        expQ.delete();
        checkOutput("load_done_count", doneCount, dc + 1);
        @(negedge clk);
        checkOutput("rdata_valid_low_after_load", {31'd0, bus.rdata_valid}, 32'd0);
        checkOutput("rdata_hold", bus.rdata, lastVal);
        #1;
    endtask

    task automatic doStore(input int base, input int stride, input int len, input int gapIdx);
        int dc;
        dc = doneCount;
        checkOutput("wdata_ready_idle", {31'd0, bus.wdata_ready}, 32'd0);
        applyStimulus(1'b1, base, stride, len);
        for (int k = 0; k < len; k++) begin
            if (k == gapIdx) begin
                bus.wdata_valid = 1'b0;
                @(negedge clk);
                checkOutput("wdata_ready_stall", {31'd0, bus.wdata_ready}, 32'd1);
                checkOutput("no_done_in_stall", {31'd0, bus.done}, 32'd0);
                @(posedge clk);
                #1;
            end
            bus.wdata       = sd[k];
            bus.wdata_valid = 1'b1;
            @(negedge clk);
            checkOutput("wdata_ready_store", {31'd0, bus.wdata_ready}, 32'd1);
            @(posedge clk);
            #1;
            model[(base + k * stride) % 32] = sd[k];
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        checkOutput("store_done", {31'd0, bus.done}, 32'd1);
        checkOutput("ready_in_done_cycle", {31'd0, bus.req_ready}, 32'd1);
        #1;
        checkOutput("store_done_count", doneCount, dc + 1);
    endtask

    initial begin
        int dc;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_base    = '0;
        bus.req_stride  = '0;
        bus.req_len     = '0;
        bus.wdata       = '0;
        bus.wdata_valid = 1'b0;
        resetModel();
        @(negedge clk);
        doReset();

        doLoad(0, 1, 4);

        sd[0] = 32'hA; sd[1] = 32'hB; sd[2] = 32'hC; sd[3] = 32'h0;
        doStore(30, 1, 3, 1);
        doLoad(30, 1, 3);

        doLoad(5, 3, 4);
        doLoad(9, 0, 3);

        dc = doneCount;
        applyStimulus(1'b1, 3, 1, 0);
        @(negedge clk);
        checkOutput("zero_len_done", {31'd0, bus.done}, 32'd1);
        checkOutput("zero_len_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        checkOutput("zero_len_ready", {31'd0, bus.req_ready}, 32'd1);
        #1;
        checkOutput("zero_len_done_count", doneCount, dc + 1);
        doLoad(3, 1, 1);

        sd[0] = 32'hDEAD_0001; sd[1] = 32'hBEEF_0002;
        doStore(20, 1, 2, -1);
        doLoad(20, 1, 2);

        doLoad(28, 7, 4);

        dc = doneCount;
        applyStimulus(1'b1, 10, 2, 5);
        bus.wdata = 32'h1111_0000; bus.wdata_valid = 1'b1;
        @(posedge clk); #1;
        bus.wdata = 32'h1111_0001;
        @(posedge clk); #1;
        bus.wdata = 32'h1111_0002;
        @(negedge clk);
        doReset();
        checkOutput("no_done_after_abort", doneCount, dc);
        doLoad(12, 0, 1);
        doLoad(10, 2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
